// File: rtl/and_vec_pkg.sv
// Shared types and helpers for the gate-sequencer family (and/or/xor variants).
package and_vec_pkg;

  localparam int unsigned MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Reduction AND over the low 'width' bits; bits above width are ignored.
  function automatic logic expected_and(input logic [MAX_WIDTH-1:0] v,
                                        input int unsigned width);
    logic r;
    r = 1'b1;
    for (int i = 0; i < int'(MAX_WIDTH); i++) begin
      if (i < int'(width)) r = r & v[3'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/and_vector_sequencer_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD-1 and flags the final cycle of each vector.
module hold_timer #(
  parameter int unsigned HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int unsigned CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clear || (cnt == LAST_CNT)) cnt_d = '0;
    else                            cnt_d = cnt + CW'(1);
  end

  // last is registered off the next count so it lines up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      last <= (HOLD == 1);
    end else begin
      cnt  <= cnt_d;
      last <= (cnt_d == LAST_CNT);
    end
  end

endmodule

// File: rtl/and_vector_sequencer.sv
// Walks every input combination of an AND gate, holds each for HOLD cycles and
// scores the gate output, reporting pass, error count and the first bad vector.
module and_vector_sequencer
  import and_vec_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned HOLD  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] vec,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail
);

  localparam logic [WIDTH-1:0] VEC_MAX = '1;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("and_vector_sequencer: WIDTH out of range");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("and_vector_sequencer: HOLD out of range");
  end

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] vec_d;
  logic [WIDTH:0]   err_d;
  logic [WIDTH-1:0] ff_d;
  logic             busy_d;
  logic             done_d;
  logic             pass_d;
  logic             timer_clear;
  logic             last;
  logic             mismatch;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .last  (last)
  );

  // Next-state, vector stepping and scoring.
  always_comb begin
    state_d     = state;
    vec_d       = vec;
    err_d       = err_count;
    ff_d        = first_fail;
    mismatch    = 1'b0;
    timer_clear = (state != DRIVE);

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
        end
      end
      DRIVE: begin
        if (last) begin
          mismatch = (y_in != expected_and(MAX_WIDTH'(vec), WIDTH));
          if (mismatch) begin
            err_d = err_count + (WIDTH + 1)'(1);
            if (err_count == '0) ff_d = vec;
          end
          if (vec == VEC_MAX) state_d = DONE;
          else                vec_d   = vec + WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_d;
      vec        <= vec_d;
      err_count  <= err_d;
      first_fail <= ff_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

endmodule

// File: tb/tb_and_vector_sequencer.sv
// Bench for and_vector_sequencer: two instances (2-bit/HOLD 10, 3-bit/HOLD 1)
// driven with good and stuck-at gates, checked every cycle against a sweep model.
module tb_and_vector_sequencer;

  localparam int W0 = 2;
  localparam int H0 = 10;
  localparam int W1 = 3;
  localparam int H1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, start0, start1;
  int   mode0, mode1;  // 0 good gate, 1 stuck-at-1, 2 stuck-at-0

  logic [W0-1:0] vec0, ff0;
  logic [W0:0]   err0;
  logic          y0, busy0, done0, pass0;
  logic [W1-1:0] vec1, ff1;
  logic [W1:0]   err1;
  logic          y1, busy1, done1, pass1;

  int n_cmp  = 0;
  int n_fail = 0;
  bit en     = 1'b0;

  function automatic logic gate(input int mode, input int v, input int w);
    if (mode == 0) return (v == (1 << w) - 1);
    return (mode == 1);
  endfunction

  assign y0 = gate(mode0, int'(vec0), W0);
  assign y1 = gate(mode1, int'(vec1), W1);

  and_vector_sequencer #(.WIDTH(W0), .HOLD(H0)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .vec(vec0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
  );

  and_vector_sequencer #(.WIDTH(W1), .HOLD(H1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .vec(vec1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mismatches among vectors 0..nv-1 for a given gate behaviour.
  function automatic int n_err(input int mode, input int w, input int nv);
    int n = 0;
    for (int v = 0; v < nv; v++)
      if (gate(mode, v, w) != (v == (1 << w) - 1)) n++;
    return n;
  endfunction

  function automatic int first_bad(input int mode, input int w, input int nv);
    for (int v = 0; v < nv; v++)
      if (gate(mode, v, w) != (v == (1 << w) - 1)) return v;
    return 0;
  endfunction

  // Model: phase 0 idle, 1 sweeping (cyc = busy cycle number from 1), 2 done.
  int ph[2];
  int cyc[2];
  int mm[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic r, s;
      int   w, h, md;
      r  = (i == 0) ? rst0 : rst1;
      s  = (i == 0) ? start0 : start1;
      md = (i == 0) ? mode0 : mode1;
      w  = (i == 0) ? W0 : W1;
      h  = (i == 0) ? H0 : H1;
      if (r) begin
        ph[i] = 0; cyc[i] = 0;
      end else if (ph[i] == 1) begin
        if (cyc[i] == (1 << w) * h) ph[i] = 2;
        else cyc[i]++;
      end else if (s) begin
        ph[i] = 1; cyc[i] = 1; mm[i] = md;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        int w, h, k, ev, eb, ed, ep, ee, ef;
        w = (i == 0) ? W0 : W1;
        h = (i == 0) ? H0 : H1;
        ev = 0; eb = 0; ed = 0; ep = 0; ee = 0; ef = 0;
        if (ph[i] == 1) begin
          k  = (cyc[i] - 1) / h;
          ev = k; eb = 1;
          ee = n_err(mm[i], w, k);
          ef = first_bad(mm[i], w, k);
        end else if (ph[i] == 2) begin
          ev = (1 << w) - 1; ed = 1;
          ee = n_err(mm[i], w, 1 << w);
          ef = first_bad(mm[i], w, 1 << w);
          ep = (ee == 0) ? 1 : 0;
        end
        check($sformatf("vec%0d", i),  (i == 0) ? int'(vec0)  : int'(vec1),  ev);
        check($sformatf("busy%0d", i), (i == 0) ? int'(busy0) : int'(busy1), eb);
        check($sformatf("done%0d", i), (i == 0) ? int'(done0) : int'(done1), ed);
        check($sformatf("pass%0d", i), (i == 0) ? int'(pass0) : int'(pass1), ep);
        check($sformatf("err%0d", i),  (i == 0) ? int'(err0)  : int'(err1),  ee);
        if (ee != 0)
          check($sformatf("first_fail%0d", i), (i == 0) ? int'(ff0) : int'(ff1), ef);
      end
    end
  end

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) @(negedge clk);
  endtask

  task automatic pulse_start0;
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
  endtask

  // Counts busy cycles of instance 0 (bounded); optionally pokes start mid-sweep.
  task automatic sweep0(input bit poke, output int n, output int seen [64]);
    n = 0;
    while (busy0 && n < 1000) begin
      if (n < 64) seen[n] = int'(vec0);
      if (poke && n == 5) start0 = 1'b1;
      else if (poke && n == 6) start0 = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen [64];
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mode0 = 0; mode1 = 0;
    tick(2);
    en = 1'b1;
    rst0 = 1'b0; rst1 = 1'b0;
    tick(20);
    check("idle_vec", int'(vec0), 0);
    check("idle_busy", int'(busy0), 0);
    check("idle_done", int'(done1), 0);

    // Good gate, WIDTH=2 HOLD=10.
    pulse_start0;
    sweep0(1'b0, n, seen);
    check("good_busy_len", n, 40);
    check("good_vec_c0", seen[0], 0);
    check("good_vec_c9", seen[9], 0);
    check("good_vec_c10", seen[10], 1);
    check("good_vec_c39", seen[39], 3);
    check("good_done", int'(done0), 1);
    check("good_pass", int'(pass0), 1);
    check("good_err", int'(err0), 0);
    tick(3);

    // Stuck-at-1 gate.
    mode0 = 1;
    pulse_start0;
    check("restart_done_drop", int'(done0), 0);
    sweep0(1'b0, n, seen);
    check("s1_busy_len", n, 40);
    check("s1_err", int'(err0), 3);
    check("s1_first_fail", int'(ff0), 0);
    check("s1_pass", int'(pass0), 0);
    tick(2);

    // Restart with good gate; start during the sweep must be ignored.
    mode0 = 0;
    pulse_start0;
    check("rs_err_cleared", int'(err0), 0);
    check("rs_done_drop", int'(done0), 0);
    sweep0(1'b1, n, seen);
    check("rs_busy_len", n, 40);
    check("rs_vec_c10", seen[10], 1);
    check("rs_pass", int'(pass0), 1);
    tick(2);

    // Stuck-at-0 gate, WIDTH=3 HOLD=1.
    mode1 = 2;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    n = 0;
    while (busy1 && n < 1000) begin n++; @(negedge clk); end
    check("s0_busy_len", n, 8);
    check("s0_err", int'(err1), 1);
    check("s0_first_fail", int'(ff1), 7);
    check("s0_pass", int'(pass1), 0);
    tick(2);

    // Mid-sweep reset, then a clean sweep.
    mode0 = 1;
    pulse_start0;
    tick(14);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("mr_vec", int'(vec0), 0);
    check("mr_busy", int'(busy0), 0);
    check("mr_done", int'(done0), 0);
    check("mr_err", int'(err0), 0);
    check("mr_ff", int'(ff0), 0);
    tick(2);
    mode0 = 0;
    pulse_start0;
    sweep0(1'b0, n, seen);
    check("mr_clean_len", n, 40);
    check("mr_clean_pass", int'(pass0), 1);
    tick(3);

    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
